vga_sync_gen: RTL and testbench

- Downstream consumer of the 50 MHz→25 MHz divider stage. Runs on the 50 MHz `clk` and uses the divider's 25 MHz output as a pixel-enable strobe.
- Generates 640x480@60 Hz VGA timing: hsync, vsync, active-video flag and pixel coordinates.
- Feeds the Drums Hero renderer (note lanes, score) and the VGA pins.

---
 rtl/vga_sync_gen.sv | 159 +++++++++++++++
 tb/tb_vga_sync_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// 640x480@60 Hz VGA timing generator. Runs on the 50 MHz system clock and
// advances one pixel on every clock edge where the 25 MHz pixel strobe
// (pix_en) is high. Produces active-low hsync/vsync, the active-video flag,
// the current pixel coordinates and a one-clk end-of-frame pulse.
//
// Ports:
//   clk        in   50 MHz system clock
//   rst_n      in   asynchronous active-low reset
//   pix_en     in   pixel strobe (level-sensitive enable, sampled at clk)
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  high while (pixel_x, pixel_y) is in the visible area
//   pixel_x    out  current column, 0..H_TOTAL-1
//   pixel_y    out  current line,   0..V_TOTAL-1
//   frame_tick out  one-clk pulse after the pixel edge that wraps the frame
//
// Build option:
//   VGA_SYNC_OUTREG_EN  when defined, hsync/vsync/video_on/pixel_x/pixel_y
//                       come from flops loaded with the next-state decode on
//                       the same pix_en edges the counters use. Undefined:
//                       these outputs are decoded combinationally.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    // Sync/blank decode of a counter pair: {hsync_n, vsync_n, video_on}.
    function automatic logic [2:0] sync_decode(input logic [9:0] h,
                                               input logic [9:0] v);
        logic hs_n;
        logic vs_n;
        logic von;
        hs_n = !((h >= HS_START) && (h <= HS_END));
        vs_n = !((v >= VS_START) && (v <= VS_END));
        von  = (h < H_VIS) && (v < V_VIS);
        return {hs_n, vs_n, von};
    endfunction

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       frame_tick_q, frame_tick_d;

    // Counter next-state: everything holds unless the pixel strobe is high.
    always_comb begin
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        frame_tick_d = 1'b0;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d      = '0;
                    frame_tick_d = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;

`ifdef VGA_SYNC_OUTREG_EN
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic [9:0] pixel_x_q, pixel_x_d;
    logic [9:0] pixel_y_q, pixel_y_d;

    // Decode the counters' next state so the output flops line up with the
    // counter flops after the same strobe edge.
    always_comb begin
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        video_on_d = video_on_q;
        pixel_x_d  = pixel_x_q;
        pixel_y_d  = pixel_y_q;
        if (pix_en) begin
            {hsync_d, vsync_d, video_on_d} = sync_decode(h_cnt_d, v_cnt_d);
            pixel_x_d = h_cnt_d;
            pixel_y_d = v_cnt_d;
        end
    end

    // video_on resets low: the flop has not yet seen a decoded pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
            pixel_x_q  <= '0;
            pixel_y_q  <= '0;
        end else begin
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
            pixel_x_q  <= pixel_x_d;
            pixel_y_q  <= pixel_y_d;
        end
    end

    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = video_on_q;
    assign pixel_x  = pixel_x_q;
    assign pixel_y  = pixel_y_q;
`else
    assign {hsync, vsync, video_on} = sync_decode(h_cnt_q, v_cnt_q);
    assign pixel_x = h_cnt_q;
    assign pixel_y = v_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Two instances share one stimulus: a full-size 640x480 generator and a
// reduced-geometry one (30x15 totals) so that whole frames fit in a short run.
// The reference model counts pixel strobes since reset and derives position
// and sync/blank levels from that count with plain division/modulo.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  // Small geometry
  localparam int S_HD = 16, S_HF = 4, S_HS = 6, S_HB = 4;
  localparam int S_VD = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_FRAME = (S_HD + S_HF + S_HS + S_HB) * (S_VD + S_VF + S_VS + S_VB);
  localparam int B_FRAME = 800 * 525;

`ifdef VGA_SYNC_OUTREG_EN
  localparam logic VON_RST = 1'b0;
`else
  localparam logic VON_RST = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  logic hsync_b, vsync_b, video_on_b, frame_tick_b;
  logic [9:0] pixel_x_b, pixel_y_b;
  logic hsync_s, vsync_s, video_on_s, frame_tick_s;
  logic [9:0] pixel_x_s, pixel_y_s;

  int compared = 0;
  int mismatched = 0;

  // clock / reset block
  always #5 clk = ~clk;

  vga_sync_gen dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
    .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .frame_tick(frame_tick_b)
  );

  vga_sync_gen #(
    .H_DISPLAY(S_HD), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_DISPLAY(S_VD), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s),
    .pixel_x(pixel_x_s), .pixel_y(pixel_y_s), .frame_tick(frame_tick_s)
  );

  // reference model: strobe count since reset and expected frame pulse
  int   n_b = 0, n_s = 0;
  logic t_b = 1'b0, t_s = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_b = 0; n_s = 0; t_b = 1'b0; t_s = 1'b0;
    end else begin
      t_b = pix_en && (((n_b + 1) % B_FRAME) == 0);
      t_s = pix_en && (((n_s + 1) % S_FRAME) == 0);
      if (pix_en) begin
        n_b = n_b + 1;
        n_s = n_s + 1;
      end
    end
  end

  function automatic logic [23:0] model_vec(input int n, input logic tick,
      input int hd, input int hf, input int hs, input int hb,
      input int vd, input int vf, input int vs, input int vb);
    int ht, vt, h, v;
    logic hs_n, vs_n, von;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    h = n % ht;
    v = (n / ht) % vt;
    hs_n = !((h >= hd + hf) && (h < hd + hf + hs));
    vs_n = !((v >= vd + vf) && (v < vd + vf + vs));
    von = (h < hd) && (v < vd);
`ifdef VGA_SYNC_OUTREG_EN
    if (n == 0) von = 1'b0;
`endif
    return {hs_n, vs_n, von, 10'(h), 10'(v), tick};
  endfunction

  logic [23:0] exp_b, exp_s, obs_b, obs_s;
  logic [23:0] rst_vec;
  always_comb exp_b = model_vec(n_b, t_b, 640, 16, 96, 48, 480, 10, 2, 33);
  always_comb exp_s = model_vec(n_s, t_s, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB);
  assign obs_b = {hsync_b, vsync_b, video_on_b, pixel_x_b, pixel_y_b, frame_tick_b};
  assign obs_s = {hsync_s, vsync_s, video_on_s, pixel_x_s, pixel_y_s, frame_tick_s};
  assign rst_vec = {1'b1, 1'b1, VON_RST, 10'd0, 10'd0, 1'b0};

  // driver: apply pix_en for one clk, return at the following negedge
  task automatic step(input logic pe);
    pix_en = pe;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pix_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      compared++;
      if (obs_b !== rst_vec) begin
        mismatched++;
        $display("FAIL reset_big cyc=%0d got=%h exp=%h", i, obs_b, rst_vec);
      end
      compared++;
      if (obs_s !== rst_vec) begin
        mismatched++;
        $display("FAIL reset_small cyc=%0d got=%h exp=%h", i, obs_s, rst_vec);
      end
    end
  endtask

  // one full line with pix_en toggling 1/0
  task automatic test_line;
    int hs_low_clks = 0;
    int first_hs_x = -1;
    int first_blank_x = -1;
    for (int k = 0; k < 1600; k++) begin
      step((k % 2) == 0);
      compared++;
      if (obs_b !== exp_b) begin
        mismatched++;
        $display("FAIL line_model k=%0d got=%h exp=%h", k, obs_b, exp_b);
      end
      if (!hsync_b) begin
        hs_low_clks++;
        if (first_hs_x < 0) first_hs_x = int'(pixel_x_b);
      end
      if (!video_on_b && first_blank_x < 0) first_blank_x = int'(pixel_x_b);
    end
    compared++;
    if (hs_low_clks != 192) begin
      mismatched++;
      $display("FAIL hsync_width got=%0d exp=192", hs_low_clks);
    end
    compared++;
    if (first_hs_x != 656) begin
      mismatched++;
      $display("FAIL hsync_start got=%0d exp=656", first_hs_x);
    end
    compared++;
    if (first_blank_x != 640) begin
      mismatched++;
      $display("FAIL blank_start got=%0d exp=640", first_blank_x);
    end
    compared++;
    if (pixel_x_b !== 10'd0 || pixel_y_b !== 10'd1) begin
      mismatched++;
      $display("FAIL line_wrap got=(%0d,%0d) exp=(0,1)", pixel_x_b, pixel_y_b);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 1)));
      compared++;
      if (obs_b !== exp_b) begin
        mismatched++;
        $display("FAIL rand_big k=%0d got=%h exp=%h", k, obs_b, exp_b);
      end
      compared++;
      if (obs_s !== exp_s) begin
        mismatched++;
        $display("FAIL rand_small k=%0d got=%h exp=%h", k, obs_s, exp_s);
      end
    end
  endtask

  // three small-geometry frames with pix_en held high
  task automatic test_frames;
    int tick_q[$];
    int vs_low = 0;
    for (int c = 0; c < 3 * S_FRAME; c++) begin
      step(1'b1);
      compared++;
      if (obs_s !== exp_s) begin
        mismatched++;
        $display("FAIL frame_model c=%0d got=%h exp=%h", c, obs_s, exp_s);
      end
      if (video_on_s && pixel_y_s >= 10'(S_VD)) begin
        compared++;
        mismatched++;
        $display("FAIL video_in_vblank y=%0d exp_video_on=0", pixel_y_s);
      end
      if (c < S_FRAME && !vsync_s) vs_low++;
      if (frame_tick_s) begin
        tick_q.push_back(c);
        compared++;
        if (pixel_x_s !== 10'd0 || pixel_y_s !== 10'd0) begin
          mismatched++;
          $display("FAIL tick_pos got=(%0d,%0d) exp=(0,0)", pixel_x_s, pixel_y_s);
        end
      end
    end
    compared++;
    if (vs_low != S_VS * (S_HD + S_HF + S_HS + S_HB)) begin
      mismatched++;
      $display("FAIL vsync_width got=%0d exp=%0d", vs_low, S_VS * (S_HD + S_HF + S_HS + S_HB));
    end
    compared++;
    if (tick_q.size() != 3) begin
      mismatched++;
      $display("FAIL tick_count got=%0d exp=3", tick_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        compared++;
        if (tick_q[i] - tick_q[i-1] != S_FRAME) begin
          mismatched++;
          $display("FAIL tick_spacing got=%0d exp=%0d", tick_q[i] - tick_q[i-1], S_FRAME);
        end
      end
    end
  endtask

  task automatic test_pause;
    logic [23:0] snap;
    int budget = 0;
    while ((n_b % 800) != 300 && budget < 2000) begin
      step(1'b1);
      budget++;
    end
    compared++;
    if (pixel_x_b !== 10'd300) begin
      mismatched++;
      $display("FAIL pause_reach got=%0d exp=300", pixel_x_b);
    end
    snap = exp_b;
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      compared++;
      if (obs_b !== snap) begin
        mismatched++;
        $display("FAIL pause_hold i=%0d got=%h exp=%h", i, obs_b, snap);
      end
    end
    step(1'b1);
    compared++;
    if (pixel_x_b !== 10'd301) begin
      mismatched++;
      $display("FAIL pause_resume got=%0d exp=301", pixel_x_b);
    end
  endtask

  task automatic test_reset_mid;
    int budget = 0;
    while ((n_b % 800) != 700 && budget < 2000) begin
      step(1'b1);
      budget++;
    end
    compared++;
    if (pixel_x_b !== 10'd700) begin
      mismatched++;
      $display("FAIL rmid_reach got=%0d exp=700", pixel_x_b);
    end
    pix_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (obs_b !== rst_vec) begin
      mismatched++;
      $display("FAIL rmid_async_big got=%h exp=%h", obs_b, rst_vec);
    end
    compared++;
    if (obs_s !== rst_vec) begin
      mismatched++;
      $display("FAIL rmid_async_small got=%h exp=%h", obs_s, rst_vec);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
    compared++;
    if (pixel_x_b !== 10'd1 || pixel_y_b !== 10'd0 || video_on_b !== 1'b1) begin
      mismatched++;
      $display("FAIL rmid_restart got=(%0d,%0d,%b) exp=(1,0,1)", pixel_x_b, pixel_y_b, video_on_b);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'($urandom_range(0, 1)));
      compared++;
      if (obs_b !== exp_b) begin
        mismatched++;
        $display("FAIL rmid_model k=%0d got=%h exp=%h", k, obs_b, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_random();
    test_frames();
    test_pause();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
